err_delay_tuner: RTL and testbench

Synchronous error-rate monitor and delay configuration controller for the resilient pipeline. It collects the asynchronous Err0 (early, shadow-latch) and Err1 (late, timing-error) indications from N_STAGES pipeline stage controllers and counts their rising edges over a fixed observation window. At the end of each window it decides whether to lengthen, shorten or hold the shared delta-delay code. It delivers each new code to the delay-line configuration logic over a 4-phase req/ack handshake.

---
 rtl/err_delay_tuner_pkg.sv | 31 +++
 rtl/err_delay_tuner_sync.sv | 38 +++
 rtl/err_delay_tuner.sv | 161 ++++++++++++++++
 tb/tb_err_delay_tuner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/err_delay_tuner_pkg.sv
// Shared types and helpers for the error-rate monitor / delay tuner.
//   state_e  : controller states
//   popcount : number of set bits in a 32-bit vector
//   sat_add  : a + b clamped to maxv
package err_delay_tuner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DECIDE,
    ST_REQ,
    ST_RELEASE
  } state_e;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, maxv}) return maxv;
    return s[31:0];
  endfunction

endpackage

// File: rtl/err_delay_tuner_sync.sv
// err_sync_edge: 2-flop synchronizer for one asynchronous level.
//   clk, rst (async, active-low)
//   d : asynchronous input level
//   o : EDGE=1 -> one-cycle pulse on a synchronized rising edge
//       EDGE=0 -> synchronized level
module err_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic o
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  if (EDGE) begin : g_edge
    logic prev_q, prev_d;
    always_comb prev_d = sync_q[1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= prev_d;
    end
    // Pulse is combinational so the accumulate register is the third flop
    // after the input.
    assign o = sync_q[1] & ~prev_q;
  end else begin : g_level
    assign o = sync_q[1];
  end

endmodule

// File: rtl/err_delay_tuner.sv
// err_delay_tuner: counts Err0/Err1 rising edges from N_STAGES stage
// controllers over WIN_LEN-cycle windows, then steps the shared delay code
// up, down or holds it, and delivers a changed code over a 4-phase req/ack.
//   clk, rst (async, active-low)
//   err0/err1 [N_STAGES] : asynchronous per-stage error levels
//   enable               : monitoring active
//   cfg_ack              : asynchronous handshake acknowledge
//   cfg_req, cfg_code    : handshake request and delay code (flop outputs)
//   err0_cnt/err1_cnt    : counts of the last completed window
//   busy                 : controller not idle
module err_delay_tuner
  import err_delay_tuner_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int WIN_LEN  = 1024,
  parameter int CNT_W    = 8,
  parameter int CODE_W   = 4,
  parameter int CODE_RST = 8,
  parameter int HI_THR   = 4,
  parameter int LO_THR   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_STAGES-1:0] err0,
  input  logic [N_STAGES-1:0] err1,
  input  logic                enable,
  input  logic                cfg_ack,
  output logic                cfg_req,
  output logic [CODE_W-1:0]   cfg_code,
  output logic [CNT_W-1:0]    err0_cnt,
  output logic [CNT_W-1:0]    err1_cnt,
  output logic                busy
);

  localparam int                TMR_W     = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [31:0]       CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(CODE_RST);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(WIN_LEN - 1);

  logic [N_STAGES-1:0] e0_rise, e1_rise;
  logic                ack_s;

  err_sync_edge #(.EDGE(1'b1)) u_sync_e0 [N_STAGES-1:0] (
    .clk(clk), .rst(rst), .d(err0), .o(e0_rise)
  );
  err_sync_edge #(.EDGE(1'b1)) u_sync_e1 [N_STAGES-1:0] (
    .clk(clk), .rst(rst), .d(err1), .o(e1_rise)
  );
  err_sync_edge #(.EDGE(1'b0)) u_sync_ack (
    .clk(clk), .rst(rst), .d(cfg_ack), .o(ack_s)
  );

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [CNT_W-1:0]    err0_cnt_q, err0_cnt_d, err1_cnt_q, err1_cnt_d;
  logic [CODE_W-1:0]   code_q, code_d, code_nxt;
  logic                req_q, req_d;

  // Increment is tested first so it wins when both rules could apply.
  always_comb begin
    code_nxt = code_q;
    if (int'(cnt1_q) >= HI_THR && code_q != CODE_MAX)
      code_nxt = code_q + 1'b1;
    else if (cnt1_q == '0 && int'(cnt0_q) <= LO_THR && code_q != '0)
      code_nxt = code_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    err0_cnt_d = err0_cnt_q;
    err1_cnt_d = err1_cnt_q;
    code_d     = code_q;
    req_d      = req_q;
    case (state_q)
      ST_IDLE: begin
        cnt0_d  = '0;
        cnt1_d  = '0;
        timer_d = '0;
        if (enable) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!enable) begin
          // partial window is thrown away
          cnt0_d  = '0;
          cnt1_d  = '0;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt0_d  = CNT_W'(sat_add(32'(cnt0_q), popcount(32'(e0_rise)), CNT_MAX));
          cnt1_d  = CNT_W'(sat_add(32'(cnt1_q), popcount(32'(e1_rise)), CNT_MAX));
          timer_d = timer_q + 1'b1;
          if (timer_q == TMR_LAST) state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        err0_cnt_d = cnt0_q;
        err1_cnt_d = cnt1_q;
        if (code_nxt != code_q) begin
          code_d  = code_nxt;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          cnt0_d  = '0;
          cnt1_d  = '0;
          timer_d = '0;
          state_d = enable ? ST_COUNT : ST_IDLE;
        end
      end
      ST_REQ: begin
        // enable is ignored until the handshake has closed
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          cnt0_d  = '0;
          cnt1_d  = '0;
          timer_d = '0;
          state_d = enable ? ST_COUNT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err0_cnt_q <= '0;
      err1_cnt_q <= '0;
      code_q     <= CODE_INIT;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err0_cnt_q <= err0_cnt_d;
      err1_cnt_q <= err1_cnt_d;
      code_q     <= code_d;
      req_q      <= req_d;
    end
  end

  assign cfg_req  = req_q;
  assign cfg_code = code_q;
  assign err0_cnt = err0_cnt_q;
  assign err1_cnt = err1_cnt_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_err_delay_tuner.sv
module tb_err_delay_tuner;

  localparam int W    = 1024;
  localparam int HI   = 4;
  localparam int LO   = 2;
  localparam int CMAX = 15;
  localparam int CRST = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] err0, err1;
  logic       enable, cfg_ack;
  logic       cfg_req, busy;
  logic [3:0] cfg_code;
  logic [7:0] err0_cnt, err1_cnt;

  err_delay_tuner dut (
    .clk(clk), .rst(rst), .err0(err0), .err1(err1), .enable(enable),
    .cfg_ack(cfg_ack), .cfg_req(cfg_req), .cfg_code(cfg_code),
    .err0_cnt(err0_cnt), .err1_cnt(err1_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int ws = 0, pe0 = 0, pe1 = 0, mcode = CRST;

  typedef struct {
    logic [3:0] m0; int n0;
    logic [3:0] m1; int n1;
    int w; bit inj; int d1; int d2; int mode;
    int e0; int e1; int code; bit req;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    if (cyc > c) chk("schedule", cyc, c);
    while (cyc < c) step();
  endtask

  function automatic int model_next(input int c, input int e0, input int e1);
    if (e1 >= HI && c < CMAX) return c + 1;
    if (e1 == 0 && e0 <= LO && c > 0) return c - 1;
    return c;
  endfunction

  function automatic int edges(input int n, input logic [3:0] m);
    int s;
    s = n * $countones(m);
    return (s > 255) ? 255 : s;
  endfunction

  // One observation window starting at ws, plus the handshake if a change
  // is expected.  mode 1: drop enable in REQ; mode 2: reset in REQ.
  task automatic run_window(input vec_t v);
    int R, A, t, np;
    bit ok;
    goto(ws + 20);
    np = (v.n0 > v.n1) ? v.n0 : v.n1;
    for (int k = 0; k < np; k++) begin
      err0 = (k < v.n0) ? v.m0 : 4'h0;
      err1 = (k < v.n1) ? v.m1 : 4'h0;
      repeat (v.w) step();
      err0 = 4'h0;
      err1 = 4'h0;
      repeat (v.w) step();
    end
    goto(ws + W);
    chk("req_in_decide", cfg_req, 0);
    chk("e0_hold", err0_cnt, pe0);
    chk("e1_hold", err1_cnt, pe1);
    goto(ws + W + 1);
    chk("err0_cnt", err0_cnt, v.e0);
    chk("err1_cnt", err1_cnt, v.e1);
    chk("req_rise", cfg_req, v.req);
    chk("cfg_code", cfg_code, v.code);
    pe0 = v.e0;
    pe1 = v.e1;
    if (!v.req) begin
      ws = ws + W + 1;
      return;
    end
    R  = cyc;
    ok = 1'b1;
    if (v.mode == 1) enable = 1'b0;
    for (int i = 0; i < v.d1; i++) begin
      if (v.inj) err1 = (i % 2 == 0) ? 4'hF : 4'h0;
      if (v.mode == 2 && i == 2) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_req", cfg_req, 0);
        chk("rst_mid_code", cfg_code, CRST);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_e1", err1_cnt, 0);
        err0 = 4'h0;
        err1 = 4'h0;
        cfg_ack = 1'b0;
        enable = 1'b1;
        step();
        step();
        rst = 1'b1;
        ws  = cyc + 1;
        pe0 = 0;
        pe1 = 0;
        return;
      end
      ok &= (cfg_req === 1'b1 && cfg_code === v.code);
      step();
    end
    err1 = 4'h0;
    cfg_ack = 1'b1;
    t = 0;
    while (cfg_req === 1'b1 && t < 40) begin
      ok &= (cfg_code === v.code);
      step();
      t++;
    end
    chk("req_fall_cycle", cyc, R + v.d1 + 3);
    chk("code_stable", ok, 1);
    repeat (v.d2) step();
    A = cyc;
    cfg_ack = 1'b0;
    goto(A + 2);
    chk("busy_release", busy, 1);
    chk("req_low_release", cfg_req, 0);
    goto(A + 3);
    chk("busy_after", busy, enable);
    ws = A + 3;
    if (v.mode == 1) begin
      repeat (10) step();
      chk("idle_stays", busy, 0);
      enable = 1'b1;
      ws = cyc + 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    //          m0  n0  m1  n1 w inj d1 d2 md  e0  e1 code req
    tbl[0]  = '{4'h0, 0, 4'h1, 5, 4, 1, 3, 7, 0,   0,  5,  9, 1};
    tbl[1]  = '{4'h4, 2, 4'h0, 0, 3, 0, 5, 2, 0,   2,  0,  8, 1};
    tbl[2]  = '{4'h7, 1, 4'h0, 0, 2, 0, 0, 0, 0,   3,  0,  8, 0};
    tbl[3]  = '{4'hF,70, 4'hF,70, 1, 0, 1, 0, 0, 255,255,  9, 1};
    for (int i = 0; i < 6; i++)
      tbl[4+i] = '{4'h0, 0, 4'hF, 1, 2, 0, 2, 1, 0, 0, 4, 10 + i, 1};
    tbl[10] = '{4'h0, 0, 4'hF, 2, 2, 0, 0, 0, 0,   0,  8, 15, 0};
    tbl[11] = '{4'h0, 0, 4'h3, 1, 2, 0, 0, 0, 0,   0,  2, 15, 0};
    tbl[12] = '{4'h0, 0, 4'h0, 0, 2, 1, 8, 4, 1,   0,  0, 14, 1};
    tbl[13] = '{4'h0, 0, 4'h0, 0, 2, 0, 4, 3, 0,   0,  0, 13, 1};
    tbl[14] = '{4'h0, 0, 4'h3, 2, 2, 0, 6, 0, 2,   0,  4, 14, 1};
    tbl[15] = '{4'h0, 0, 4'h0, 0, 2, 0, 2, 2, 0,   0,  0,  7, 1};
    tbl[16] = '{4'h0, 0, 4'h7, 1, 2, 0, 0, 0, 0,   0,  3,  7, 0};
    tbl[17] = '{4'h1, 2, 4'h0, 0, 2, 0, 1, 1, 0,   2,  0,  6, 1};

    // reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      err0    = 4'($urandom);
      err1    = 4'($urandom);
      enable  = 1'($urandom);
      cfg_ack = 1'($urandom);
      step();
    end
    chk("rst_req", cfg_req, 0);
    chk("rst_code", cfg_code, CRST);
    chk("rst_e0", err0_cnt, 0);
    chk("rst_e1", err1_cnt, 0);
    chk("rst_busy", busy, 0);
    err0 = 4'h0;
    err1 = 4'h0;
    enable = 1'b0;
    cfg_ack = 1'b0;
    step();
    rst = 1'b1;
    // edges while idle must be discarded
    repeat (3) step();
    err1 = 4'hF;
    repeat (2) step();
    err1 = 4'h0;
    repeat (20) step();
    chk("idle_busy", busy, 0);
    chk("idle_req", cfg_req, 0);
    chk("idle_e1", err1_cnt, 0);

    enable = 1'b1;
    ws = cyc + 1;
    for (int i = 0; i < 18; i++) begin
      run_window(tbl[i]);
      mcode = (tbl[i].mode == 2) ? CRST : tbl[i].code;
    end

    // randomized windows against the behavioural model
    for (int r = 0; r < 6; r++) begin
      rv.m0   = 4'($urandom);
      rv.n0   = $urandom_range(0, 3);
      rv.m1   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      rv.n1   = $urandom_range(0, 2);
      rv.w    = $urandom_range(1, 4);
      rv.inj  = 1'($urandom);
      rv.d1   = $urandom_range(0, 6);
      rv.d2   = $urandom_range(0, 6);
      rv.mode = 0;
      rv.e0   = edges(rv.n0, rv.m0);
      rv.e1   = edges(rv.n1, rv.m1);
      rv.code = model_next(mcode, rv.e0, rv.e1);
      rv.req  = (rv.code != mcode);
      run_window(rv);
      mcode = rv.code;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
